// File: rtl/credit_bp_rx_batched_if.sv
// Bundle of the push, credit-return and router-side DVR signals for the credit receiver.
// slave is the receiver's view; master is the view of whatever drives and observes it.
interface credit_bp_rx_batched_if #(
   parameter int VC_W  = 2,
   parameter int D_W   = 32,
   parameter int A_W   = 8,
   parameter int DEPTH = 8
);
   localparam int VCID_W = (VC_W > 1) ? $clog2(VC_W) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int FW     = A_W + D_W + 1;

   // Push has no ready: the transmitter only sends against credits.
   // Router side is valid/hold: o_v/o_d stay stable while i_b=1.
   // A flit moves on every cycle where o_v=1 and i_b=0.
   logic                          i_push_v;
   logic [VCID_W-1:0]             i_push_vc;
   logic [FW-1:0]                 i_push_d;
   logic                          o_crd_v;
   logic [VCID_W-1:0]             o_crd_vc;
   logic [CNT_W-1:0]              o_crd_cnt;
   logic [VC_W-1:0]               o_v;
   logic [VC_W-1:0][FW-1:0]       o_d;
   logic [VC_W-1:0]               i_b;
   logic [VC_W-1:0]               o_overflow;
   logic                          o_dbg_state;

   modport slave (
      input  i_push_v, i_push_vc, i_push_d, i_b,
      output o_crd_v, o_crd_vc, o_crd_cnt, o_v, o_d, o_overflow, o_dbg_state
   );

   modport master (
      output i_push_v, i_push_vc, i_push_d, i_b,
      input  o_crd_v, o_crd_vc, o_crd_cnt, o_v, o_d, o_overflow, o_dbg_state
   );
endinterface

// File: rtl/credit_bp_rx_batched.sv
// NoC input-port receiver: per-VC fall-through FIFOs and batched credit return.
// The FSM advertises full depth per VC after reset, then returns credits by round-robin.
module credit_bp_rx_batched #(
   parameter int VC_W          = 2,
   parameter int D_W           = 32,
   parameter int A_W           = 8,
   parameter int DEPTH         = 8,
   parameter int CREDIT_BATCH  = 4,
   parameter int FLUSH_TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   credit_bp_rx_batched_if.slave   bus
);
   localparam int VCID_W = (VC_W > 1) ? $clog2(VC_W) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int FW     = A_W + D_W + 1;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int TMR_W  = $clog2(FLUSH_TIMEOUT + 1);

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   state_e              state_q, state_d;
   logic [VCID_W-1:0]   idx_q, idx_d;
   logic [VCID_W-1:0]   rr_q, rr_d;
   logic                crd_v_q, crd_v_d;
   logic [VCID_W-1:0]   crd_vc_q, crd_vc_d;
   logic [CNT_W-1:0]    crd_cnt_q, crd_cnt_d;
   logic [VC_W-1:0]     ovf_q;

   logic [FW-1:0]       mem_q    [VC_W][DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q [VC_W];
   logic [PTR_W-1:0]    rd_ptr_q [VC_W];
   logic [CNT_W-1:0]    cnt_q    [VC_W];
   logic [CNT_W-1:0]    pend_q   [VC_W];
   logic [CNT_W-1:0]    pend_d   [VC_W];
   logic [TMR_W-1:0]    tmr_q    [VC_W];
   logic [TMR_W-1:0]    tmr_d    [VC_W];

   logic [VC_W-1:0]     push_hit, full, wr_en, pop, elig, grant;
   logic                found;
   logic [VCID_W-1:0]   sel;
   int                  cand;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // FIFO flags, eligibility and round-robin pick starting at rr_q.
   always_comb begin
      push_hit = '0;
      full     = '0;
      wr_en    = '0;
      pop      = '0;
      elig     = '0;
      found    = 1'b0;
      sel      = '0;
      cand     = 0;
      for (int v = 0; v < VC_W; v++) begin
         push_hit[v] = bus.i_push_v && (bus.i_push_vc == VCID_W'(v));
         full[v]     = (cnt_q[v] == CNT_W'(DEPTH));
         wr_en[v]    = push_hit[v] && !full[v];
         pop[v]      = (cnt_q[v] != '0) && !bus.i_b[v];
         elig[v]     = (pend_q[v] >= CNT_W'(CREDIT_BATCH)) ||
                       ((pend_q[v] != '0) && (tmr_q[v] >= TMR_W'(FLUSH_TIMEOUT)));
      end
      for (int k = 0; k < VC_W; k++) begin
         cand = (int'(rr_q) + k) % VC_W;
         if (!found && elig[cand]) begin
            found = 1'b1;
            sel   = VCID_W'(cand);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rr_d      = rr_q;
      crd_v_d   = 1'b0;
      crd_vc_d  = crd_vc_q;
      crd_cnt_d = crd_cnt_q;
      grant     = '0;
      case (state_q)
         ST_INIT: begin
            crd_v_d   = 1'b1;
            crd_vc_d  = idx_q;
            crd_cnt_d = CNT_W'(DEPTH);
            idx_d     = idx_q + 1'b1;
            if (idx_q == VCID_W'(VC_W - 1)) begin
               state_d = ST_RUN;
               idx_d   = '0;
            end
         end
         ST_RUN: begin
            if (found) begin
               crd_v_d    = 1'b1;
               crd_vc_d   = sel;
               crd_cnt_d  = pend_q[sel];
               grant[sel] = 1'b1;
               rr_d       = (sel == VCID_W'(VC_W - 1)) ? '0 : sel + 1'b1;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // A pop in the granting cycle is not part of that return; it seeds the next batch.
   always_comb begin
      for (int v = 0; v < VC_W; v++) begin
         pend_d[v] = pend_q[v] + CNT_W'(pop[v]);
         tmr_d[v]  = tmr_q[v];
         if (grant[v]) begin
            pend_d[v] = CNT_W'(pop[v]);
            tmr_d[v]  = '0;
         end else if ((pend_q[v] != '0) && (tmr_q[v] != TMR_W'(FLUSH_TIMEOUT))) begin
            tmr_d[v]  = tmr_q[v] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_INIT;
         idx_q     <= '0;
         rr_q      <= '0;
         crd_v_q   <= 1'b0;
         crd_vc_q  <= '0;
         crd_cnt_q <= '0;
         ovf_q     <= '0;
         for (int v = 0; v < VC_W; v++) begin
            wr_ptr_q[v] <= '0;
            rd_ptr_q[v] <= '0;
            cnt_q[v]    <= '0;
            pend_q[v]   <= '0;
            tmr_q[v]    <= '0;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rr_q      <= rr_d;
         crd_v_q   <= crd_v_d;
         crd_vc_q  <= crd_vc_d;
         crd_cnt_q <= crd_cnt_d;
         for (int v = 0; v < VC_W; v++) begin
            if (wr_en[v]) wr_ptr_q[v] <= ptr_inc(wr_ptr_q[v]);
            if (pop[v])   rd_ptr_q[v] <= ptr_inc(rd_ptr_q[v]);
            cnt_q[v]  <= cnt_q[v] + CNT_W'(wr_en[v]) - CNT_W'(pop[v]);
            pend_q[v] <= pend_d[v];
            tmr_q[v]  <= tmr_d[v];
            if (push_hit[v] && full[v]) ovf_q[v] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int v = 0; v < VC_W; v++) begin
         if (wr_en[v]) mem_q[v][wr_ptr_q[v]] <= bus.i_push_d;
      end
   end

   always_comb begin
      for (int v = 0; v < VC_W; v++) begin
         bus.o_v[v] = (cnt_q[v] != '0);
         bus.o_d[v] = mem_q[v][rd_ptr_q[v]];
      end
   end

   assign bus.o_crd_v     = crd_v_q;
   assign bus.o_crd_vc    = crd_vc_q;
   assign bus.o_crd_cnt   = crd_cnt_q;
   assign bus.o_overflow  = ovf_q;
   assign bus.o_dbg_state = (state_q == ST_RUN);

   a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
      !$isunknown({bus.o_v, bus.o_crd_v, bus.i_b}));
   a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
      bus.o_crd_cnt <= CNT_W'(DEPTH));
   a_cnt_nz: assert property (@(posedge clk) disable iff (!rst_n)
      bus.o_crd_v |-> (bus.o_crd_cnt != '0));

   for (genvar g = 0; g < VC_W; g++) begin : g_vc_chk
      a_d_known: assert property (@(posedge clk) disable iff (!rst_n)
         bus.o_v[g] |-> !$isunknown(bus.o_d[g]));
      a_pend_max: assert property (@(posedge clk) disable iff (!rst_n)
         !(pop[g] && !grant[g] && (pend_q[g] == CNT_W'(DEPTH))));
   end
endmodule

// File: tb/tb_credit_bp_rx_batched.sv
// Directed bench for credit_bp_rx_batched: init advertisement, batching, timeout flush,
// round-robin ties, overflow and mid-run reset, with a log of every credit return.
module tb_credit_bp_rx_batched;
   localparam int VC_W = 2;
   localparam int D_W  = 32;
   localparam int A_W  = 8;
   localparam int DEPTH = 8;
   localparam int FW   = A_W + D_W + 1;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   hits;

   logic [15:0] crd_q[$];
   logic [15:0] exp_q[$];

   credit_bp_rx_batched_if #(.VC_W(VC_W), .D_W(D_W), .A_W(A_W), .DEPTH(DEPTH)) bus ();

   credit_bp_rx_batched #(
      .VC_W(VC_W), .D_W(D_W), .A_W(A_W), .DEPTH(DEPTH),
      .CREDIT_BATCH(4), .FLUSH_TIMEOUT(16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every credit return as {vc, count}.
   always @(negedge clk) begin
      if (bus.o_crd_v === 1'b1) crd_q.push_back({8'(bus.o_crd_vc), 8'(bus.o_crd_cnt)});
   end

   function automatic logic [FW-1:0] flit(input int vc, input int k);
      return {((k % 4) == 3) ? 1'b1 : 1'b0, 8'(vc + 1), 32'hC0DE_0000 + 32'(k)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_crd(input string tag, input int vc, input int cnt);
      check({tag, "_v"}, 64'(bus.o_crd_v), 64'd1);
      check({tag, "_vc"}, 64'(bus.o_crd_vc), 64'(vc));
      check({tag, "_cnt"}, 64'(bus.o_crd_cnt), 64'(cnt));
   endtask

   task automatic check_log(input string tag);
      int n;
      check({tag, "_n"}, 64'(crd_q.size()), 64'(exp_q.size()));
      n = (crd_q.size() < exp_q.size()) ? crd_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_entry"}, 64'(crd_q[i]), 64'(exp_q[i]));
      crd_q.delete();
      exp_q.delete();
   endtask

   task automatic push(input int vc, input logic [FW-1:0] d);
      bus.i_push_v  = 1'b1;
      bus.i_push_vc = 1'(vc);
      bus.i_push_d  = d;
      step();
      bus.i_push_v  = 1'b0;
   endtask

   // Fill both VCs with 4 flits under hold, then release both together.
   task automatic do_tie();
      bus.i_b = 2'b11;
      for (int k = 0; k < 4; k++) push(0, flit(0, k));
      for (int k = 0; k < 4; k++) push(1, flit(1, k));
      bus.i_b = 2'b00;
      repeat (4) step();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.i_push_v  = 1'b0;
      bus.i_push_vc = 1'b0;
      bus.i_push_d  = '0;
      bus.i_b       = 2'b00;

      // Reset and initial advertisement
      repeat (3) step();
      check("rst_crd_v", 64'(bus.o_crd_v), 64'd0);
      check("rst_o_v", 64'(bus.o_v), 64'd0);
      check("rst_ovf", 64'(bus.o_overflow), 64'd0);
      check("rst_state", 64'(bus.o_dbg_state), 64'd0);
      rst_n = 1'b1;
      step();
      check_crd("init0", 0, 8);
      step();
      check_crd("init1", 1, 8);
      step();
      check("init_done_v", 64'(bus.o_crd_v), 64'd0);
      check("init_state", 64'(bus.o_dbg_state), 64'd1);
      check("init_ovf", 64'(bus.o_overflow), 64'd0);
      exp_q.push_back({8'd0, 8'd8});
      exp_q.push_back({8'd1, 8'd8});
      check_log("init_log");

      // Four back-to-back flits on VC0 form one batch
      check("b4_ov_pre", 64'(bus.o_v[0]), 64'd0);
      for (int k = 0; k < 4; k++) begin
         push(0, flit(0, k));
         check("b4_ov", 64'(bus.o_v[0]), 64'd1);
         check("b4_od", 64'(bus.o_d[0]), 64'(flit(0, k)));
      end
      step();
      check("b4_ov_empty", 64'(bus.o_v[0]), 64'd0);
      check("b4_no_early", 64'(bus.o_crd_v), 64'd0);
      step();
      check_crd("b4_ret", 0, 4);
      repeat (20) step();
      exp_q.push_back({8'd0, 8'd4});
      check_log("b4_log");

      // Lone flit on VC1 flushed by the timeout
      push(1, flit(1, 0));
      check("to_ov", 64'(bus.o_v[1]), 64'd1);
      check("to_od", 64'(bus.o_d[1]), 64'(flit(1, 0)));
      step();
      check("to_popped", 64'(bus.o_v[1]), 64'd0);
      hits = 0;
      repeat (16) begin
         step();
         if (bus.o_crd_v === 1'b1) hits++;
      end
      check("to_quiet", 64'(hits), 64'd0);
      step();
      check_crd("to_ret", 1, 1);
      repeat (5) step();
      exp_q.push_back({8'd1, 8'd1});
      check_log("to_log");

      // Simultaneous batches: pointer at 0 favours VC0
      do_tie();
      check("tie1_none", 64'(bus.o_crd_v), 64'd0);
      step();
      check_crd("tie1_a", 0, 4);
      step();
      check_crd("tie1_b", 1, 4);
      // VC0-only batch moves the pointer to 1
      for (int k = 0; k < 4; k++) push(0, flit(0, k + 4));
      repeat (2) step();
      check_crd("mid_ret", 0, 4);
      do_tie();
      step();
      check_crd("tie2_a", 1, 4);
      step();
      check_crd("tie2_b", 0, 4);
      repeat (20) step();
      exp_q.push_back({8'd0, 8'd4});
      exp_q.push_back({8'd1, 8'd4});
      exp_q.push_back({8'd0, 8'd4});
      exp_q.push_back({8'd1, 8'd4});
      exp_q.push_back({8'd0, 8'd4});
      check_log("tie_log");

      // Overflow: ninth flit into a held, full VC0 is dropped
      bus.i_b = 2'b01;
      for (int k = 0; k < 9; k++) begin
         push(0, flit(0, k + 10));
         if (k == 7) check("ovf_full_ok", 64'(bus.o_overflow), 64'd0);
      end
      check("ovf_set", 64'(bus.o_overflow), 64'b01);
      check("ovf_hold_v", 64'(bus.o_v[0]), 64'd1);
      check("ovf_hold_d", 64'(bus.o_d[0]), 64'(flit(0, 10)));
      bus.i_b = 2'b00;
      for (int k = 0; k < 8; k++) begin
         check("ovf_drain_d", 64'(bus.o_d[0]), 64'(flit(0, k + 10)));
         step();
      end
      check("ovf_drained", 64'(bus.o_v[0]), 64'd0);
      check("ovf_sticky", 64'(bus.o_overflow), 64'b01);
      repeat (10) step();
      exp_q.push_back({8'd0, 8'd4});
      exp_q.push_back({8'd0, 8'd4});
      check_log("ovf_log");

      // Mid-run reset with 3 flits buffered and 2 credits pending on VC0
      bus.i_b = 2'b01;
      for (int k = 0; k < 5; k++) push(0, flit(0, k + 20));
      bus.i_b = 2'b00;
      repeat (2) step();
      bus.i_b = 2'b01;
      check("mr_pre_v", 64'(bus.o_v[0]), 64'd1);
      check("mr_pre_d", 64'(bus.o_d[0]), 64'(flit(0, 22)));
      rst_n = 1'b0;
      step();
      check("mr_o_v", 64'(bus.o_v), 64'd0);
      check("mr_crd_v", 64'(bus.o_crd_v), 64'd0);
      check("mr_ovf", 64'(bus.o_overflow), 64'd0);
      check("mr_state", 64'(bus.o_dbg_state), 64'd0);
      step();
      rst_n = 1'b1;
      bus.i_b = 2'b00;
      step();
      check_crd("mr_init0", 0, 8);
      step();
      check_crd("mr_init1", 1, 8);
      step();
      check("mr_init_done", 64'(bus.o_crd_v), 64'd0);
      repeat (25) step();
      check("mr_o_v_late", 64'(bus.o_v), 64'd0);
      exp_q.push_back({8'd0, 8'd8});
      exp_q.push_back({8'd1, 8'd8});
      check_log("mr_log");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
